// File: rtl/key_pkg.sv
// Shared defaults and level encoding for the push-button debouncer.
package key_pkg;

    localparam int unsigned DEF_NUM_KEYS = 4;
    // 50 MHz clock x 20 ms stable window = 1_000_000 cycles.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_CNT_W = 24;

    localparam logic KEY_RELEASED = 1'b0;
    localparam logic KEY_HELD     = 1'b1;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, stable-time counter, level and edge pulses.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q, press_q, release_q;
    logic             samp;

    assign samp = ~s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            cnt_q     <= '0;
            level_q   <= KEY_RELEASED;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= key_n;
            s2_q      <= s1_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (samp == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= CNT_LAST) begin
                // Stable long enough: accept the new level and emit its pulse.
                level_q   <= samp;
                cnt_q     <= '0;
                press_q   <= (samp == KEY_HELD);
                release_q <= (samp == KEY_RELEASED);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces NUM_KEYS active-low push-buttons into clean levels and press/release pulses.
module key_debouncer
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = DEF_NUM_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_press
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key_n       (key_n[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

    // OR of registered pulses only, so no path from key_n reaches this output.
    assign any_press = |key_press;

endmodule
